// File: rtl/pwm_carrier_comparator.sv
// pwm_carrier_comparator: prescaled sawtooth/triangle carrier compared against a
// double-buffered [low, high) window, producing the raw complementary gate pair.
module pwm_carrier_comparator #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [7:0]               prescale,
    input  logic [COUNTER_WIDTH-1:0] period,
    input  logic [COUNTER_WIDTH-1:0] compare_low,
    input  logic [COUNTER_WIDTH-1:0] compare_high,
    output logic [COUNTER_WIDTH-1:0] counter,
    output logic                     out_a,
    output logic                     out_b,
    output logic                     sync_out
);
    logic [7:0]               prescale_cnt;
    logic                     dir;
    logic [COUNTER_WIDTH-1:0] period_act;
    logic [COUNTER_WIDTH-1:0] low_act;
    logic [COUNTER_WIDTH-1:0] high_act;
    logic                     tick;
    logic                     down;
    logic                     wrap;
    logic                     in_win;
    logic                     dir_nx;
    logic [COUNTER_WIDTH-1:0] cnt_nx;

    // Out-of-range states (e.g. after an unsupported mode change) fall into the >= turn/wrap paths.
    always_comb begin
        tick   = prescale_cnt == prescale;
        down   = mode && (dir || counter >= period_act);
        wrap   = period_act == '0 || (mode ? down && counter <= COUNTER_WIDTH'(1) : counter >= period_act);
        cnt_nx = wrap ? '0 : down ? counter - 1'b1 : counter + 1'b1;
        dir_nx = !wrap && down;
        in_win = counter >= low_act && counter < high_act;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescale_cnt <= '0;
            counter      <= '0;
            dir          <= 1'b0;
            period_act   <= '0;
            low_act      <= '0;
            high_act     <= '0;
            out_a        <= 1'b0;
            out_b        <= 1'b0;
            sync_out     <= 1'b0;
        end else if (!enable) begin
            prescale_cnt <= '0;
            counter      <= '0;
            dir          <= 1'b0;
            period_act   <= period;
            low_act      <= compare_low;
            high_act     <= compare_high;
            out_a        <= 1'b0;
            out_b        <= 1'b0;
            sync_out     <= 1'b0;
        end else begin
            prescale_cnt <= tick ? '0 : prescale_cnt + 1'b1;
            out_a        <= in_win;
            out_b        <= !in_win;
            sync_out     <= tick && wrap;
            if (tick) begin
                counter <= cnt_nx;
                dir     <= dir_nx;
                if (wrap) begin
                    period_act <= period;
                    low_act    <= compare_low;
                    high_act   <= compare_high;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_carrier_comparator.sv
// tb_pwm_carrier_comparator: directed stimulus, checked every cycle against a
// phase-index carrier model plus hand-computed literal expectations.
module tb_pwm_carrier_comparator;
    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        mode;
    logic [7:0]  prescale;
    logic [15:0] period;
    logic [15:0] compare_low;
    logic [15:0] compare_high;
    logic [15:0] counter;
    logic        out_a;
    logic        out_b;
    logic        sync_out;

    int total = 0;
    int bad = 0;
    bit done = 0;

    pwm_carrier_comparator #(.COUNTER_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode),
        .prescale(prescale), .period(period), .compare_low(compare_low),
        .compare_high(compare_high), .counter(counter), .out_a(out_a),
        .out_b(out_b), .sync_out(sync_out)
    );

    always #5 clock = ~clock;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position k inside the current period; carrier value derived from k.
    int mk, mpc, mp, mlo, mhi, mlen, mc;
    bit ma, mb, ms, mtick;

    function automatic int carrier(int k, int p, bit md);
        return (md && k > p) ? 2 * p - k : k;
    endfunction

    always @(posedge clock) begin
        mc = carrier(mk, mp, mode);
        if (reset) begin
            mk <= 0; mpc <= 0; mp <= 0; mlo <= 0; mhi <= 0;
            ma <= 0; mb <= 0; ms <= 0;
        end else if (!enable) begin
            mk <= 0; mpc <= 0;
            mp <= int'(period); mlo <= int'(compare_low); mhi <= int'(compare_high);
            ma <= 0; mb <= 0; ms <= 0;
        end else begin
            ma <= (mc >= mlo && mc < mhi);
            mb <= !(mc >= mlo && mc < mhi);
            mtick = mpc == int'(prescale);
            mpc <= mtick ? 0 : mpc + 1;
            mlen = mode ? 2 * mp : mp + 1;
            if (mlen < 1) mlen = 1;
            ms <= mtick && (mk + 1 >= mlen);
            if (mtick) begin
                if (mk + 1 >= mlen) begin
                    mk <= 0;
                    mp <= int'(period); mlo <= int'(compare_low); mhi <= int'(compare_high);
                end else begin
                    mk <= mk + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!done) begin
            check("model_counter", int'(counter), carrier(mk, mp, mode));
            check("model_out_a", int'(out_a), int'(ma));
            check("model_out_b", int'(out_b), int'(mb));
            check("model_sync", int'(sync_out), int'(ms));
        end
    end

    task automatic wait_cnt(int v);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (int'(counter) != v && n < 300);
        if (int'(counter) != v) check("wait_cnt_timeout", int'(counter), v);
    endtask

    task automatic wait_sync(string name, int exp);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!sync_out && n < 200);
        check(name, n, exp);
    endtask

    initial begin
        reset = 1; enable = 1; mode = 0; prescale = 0;
        period = 9; compare_low = 2; compare_high = 5;
        repeat (2) @(negedge clock);
        check("rst_counter", int'(counter), 0);
        check("rst_out_a", int'(out_a), 0);
        check("rst_out_b", int'(out_b), 0);
        check("rst_sync", int'(sync_out), 0);
        reset = 0;
        // Actives are 0 after reset, so the first tick wraps and loads P=9.
        for (int k = 1; k <= 21; k++) begin
            @(negedge clock);
            check("saw_counter", int'(counter), (k - 1) % 10);
            check("saw_out_a", int'(out_a), int'(k >= 2 && (k - 2) % 10 >= 2 && (k - 2) % 10 <= 4));
            check("saw_sync", int'(sync_out), int'((k - 1) % 10 == 0));
        end
        // compare_high change mid-period only applies after the wrap
        wait_cnt(3);
        compare_high = 8;
        wait_cnt(6);
        check("shadow_high_old", int'(out_a), 0);
        wait_cnt(0);
        wait_cnt(7);
        check("shadow_high_new", int'(out_a), 1);
        // period change mid-period
        wait_cnt(2);
        period = 4;
        wait_cnt(9);
        @(negedge clock);
        check("shadow_p_wrap9", int'(counter), 0);
        wait_cnt(4);
        @(negedge clock);
        check("shadow_p_wrap4", int'(counter), 0);
        // empty window
        period = 9; compare_low = 6; compare_high = 6;
        wait_cnt(4);
        wait_cnt(0);
        @(negedge clock);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("empty_out_a", int'(out_a), 0);
            check("empty_out_b", int'(out_b), 1);
        end
        // window extends past the top
        compare_low = 2; compare_high = 12;
        wait_cnt(9);
        wait_cnt(0);
        wait_cnt(9);
        check("wide_at9", int'(out_a), 1);
        @(negedge clock);
        check("wide_top", int'(out_a), 1);
        check("wide_top_cnt", int'(counter), 0);
        // enable drop at 6, then re-enable
        wait_cnt(6);
        enable = 0;
        @(negedge clock);
        check("dis_counter", int'(counter), 0);
        check("dis_out_a", int'(out_a), 0);
        check("dis_out_b", int'(out_b), 0);
        repeat (2) @(negedge clock);
        enable = 1;
        @(negedge clock);
        check("reen_counter", int'(counter), 1);
        check("reen_sync", int'(sync_out), 0);
        wait_sync("reen_first_sync", 9);
        // P = 0: every tick is a wrap
        period = 0;
        wait_cnt(9);
        wait_cnt(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("p0_sync", int'(sync_out), 1);
            check("p0_counter", int'(counter), 0);
        end
        // triangle, configured while disabled
        enable = 0; mode = 1; prescale = 1; period = 4; compare_low = 1; compare_high = 3;
        repeat (2) @(negedge clock);
        enable = 1;
        wait_sync("tri_first_sync", 16);
        wait_sync("tri_period", 16);
        wait_cnt(4);
        wait_cnt(2);
        @(negedge clock);
        check("tri_down_out_a", int'(out_a), 1);
        check("tri_down_cnt", int'(counter), 2);
        // reset on the down-slope
        wait_cnt(4);
        wait_cnt(3);
        reset = 1;
        @(negedge clock);
        check("rst_mid_counter", int'(counter), 0);
        check("rst_mid_out_a", int'(out_a), 0);
        check("rst_mid_out_b", int'(out_b), 0);
        check("rst_mid_sync", int'(sync_out), 0);
        reset = 0;
        repeat (40) @(negedge clock);
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
